// File: rtl/mux_ctrl.sv
// Selection controller in front of the project mux: synchronises the selection pins,
// steps the project address and gates the mux enable and data words behind a guard interval.
module mux_ctrl #(
    parameter int unsigned NUM_PROJECTS = 24,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned GUARD_CYCLES = 2,
    localparam int unsigned IW_W        = 18,
    localparam int unsigned OW_W        = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    input  logic [IW_W-1:0]   iw_in,
    input  logic [OW_W-1:0]   ow_in,
    output logic [ADDR_W-1:0] addr,
    output logic              ena,
    output logic [IW_W-1:0]   iw,
    output logic [OW_W-1:0]   ow_out
);

    localparam int unsigned GCNT_W = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETTLE = 2'b01,
        S_RUN    = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic [SYNC_STAGES-1:0] r_inc_sync;
    logic [SYNC_STAGES-1:0] r_ena_sync;
    logic                   r_inc_prev;
    logic [ADDR_W-1:0]      r_addr;
    state_t                 r_state;
    logic [GCNT_W-1:0]      r_gcnt;
    logic [IW_W-1:0]        r_iw;
    logic [OW_W-1:0]        r_ow;

    logic                   w_sel_rst_s;
    logic                   w_inc_s;
    logic                   w_ena_s;
    logic                   w_inc_edge;
    state_t                 w_state_nxt;
    logic [GCNT_W-1:0]      w_gcnt_nxt;

    // Control-pin synchronisers and increment edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_sync <= '0;
            r_inc_sync <= '0;
            r_ena_sync <= '0;
            r_inc_prev <= 1'b0;
        end else begin
            r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], ctrl_sel_rst_n};
            r_inc_sync <= {r_inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
            r_ena_sync <= {r_ena_sync[SYNC_STAGES-2:0], ctrl_ena};
            r_inc_prev <= w_inc_s;
        end
    end

    assign w_sel_rst_s = r_sel_sync[SYNC_STAGES-1];
    assign w_inc_s     = r_inc_sync[SYNC_STAGES-1];
    assign w_ena_s     = r_ena_sync[SYNC_STAGES-1];
    assign w_inc_edge  = w_inc_s & ~r_inc_prev;

    // Address counter; selection reset overrides an increment in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (!w_sel_rst_s) begin
            r_addr <= '0;
        end else if (w_inc_edge) begin
            if (r_addr == ADDR_W'(NUM_PROJECTS - 1)) begin
                r_addr <= '0;
            end else begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gcnt  <= w_gcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        if (!w_sel_rst_s) begin
            w_state_nxt = S_IDLE;
            w_gcnt_nxt  = '0;
        end else if (w_inc_edge) begin
            w_state_nxt = S_SETTLE;
            w_gcnt_nxt  = GCNT_W'(GUARD_CYCLES);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ena_s) begin
                        w_state_nxt = S_SETTLE;
                        w_gcnt_nxt  = GCNT_W'(GUARD_CYCLES);
                    end
                end
                S_SETTLE: begin
                    w_gcnt_nxt = r_gcnt - GCNT_W'(1);
                    if (r_gcnt == GCNT_W'(1)) begin
                        w_state_nxt = w_ena_s ? S_RUN : S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!w_ena_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_gcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Data words are only passed while the selected project is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iw <= '0;
            r_ow <= '0;
        end else begin
            r_iw <= (r_state == S_RUN) ? iw_in : '0;
            r_ow <= (r_state == S_RUN) ? ow_in : '0;
        end
    end

    assign addr   = r_addr;
    assign ena    = (r_state == S_RUN);
    assign iw     = r_iw;
    assign ow_out = r_ow;

endmodule

// File: tb/tb_mux_ctrl.sv
// Bench for mux_ctrl: directed scenarios with literal expectations plus a randomized
// phase, all outputs compared every cycle against a guard-time reference model.
module tb_mux_ctrl;

    localparam int unsigned NP = 24;
    localparam int unsigned AW = 5;
    localparam int unsigned SS = 2;
    localparam int unsigned GC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sel_rst_n;
    logic          inc;
    logic          en;
    logic [17:0]   iw_in;
    logic [23:0]   ow_in;
    logic [AW-1:0] addr;
    logic          ena;
    logic [17:0]   iw;
    logic [23:0]   ow_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mux_ctrl #(
        .NUM_PROJECTS(NP),
        .ADDR_W      (AW),
        .SYNC_STAGES (SS),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl_sel_rst_n(sel_rst_n),
        .ctrl_sel_inc  (inc),
        .ctrl_ena      (en),
        .iw_in         (iw_in),
        .ow_in         (ow_in),
        .addr          (addr),
        .ena           (ena),
        .iw            (iw),
        .ow_out        (ow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin history delayed by SS edges, guard time remaining, running flag
    bit          q_sel [SS];
    bit          q_inc [SS];
    bit          q_ena [SS];
    bit          m_prev_inc = 1'b0;
    bit          m_run      = 1'b0;
    int          m_guard    = 0;
    int          m_addr     = 0;
    logic [17:0] m_iw       = '0;
    logic [23:0] m_ow       = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) begin
                q_sel[i] = 1'b0;
                q_inc[i] = 1'b0;
                q_ena[i] = 1'b0;
            end
            m_prev_inc = 1'b0;
            m_run      = 1'b0;
            m_guard    = 0;
            m_addr     = 0;
            m_iw       = '0;
            m_ow       = '0;
        end else begin
            bit s_sel;
            bit s_inc;
            bit s_ena;
            bit rise;
            s_sel = q_sel[SS-1];
            s_inc = q_inc[SS-1];
            s_ena = q_ena[SS-1];
            rise  = s_inc && !m_prev_inc;
            m_iw  = m_run ? iw_in : 18'h0;
            m_ow  = m_run ? ow_in : 24'h0;
            m_prev_inc = s_inc;
            if (!s_sel) begin
                m_addr  = 0;
                m_run   = 1'b0;
                m_guard = 0;
            end else if (rise) begin
                m_addr  = (m_addr + 1) % NP;
                m_run   = 1'b0;
                m_guard = GC;
            end else if (m_guard > 0) begin
                m_guard--;
                if (m_guard == 0) m_run = s_ena;
            end else if (!m_run && s_ena) begin
                m_guard = GC;
            end else if (m_run && !s_ena) begin
                m_run = 1'b0;
            end
            for (int i = SS - 1; i > 0; i--) begin
                q_sel[i] = q_sel[i-1];
                q_inc[i] = q_inc[i-1];
                q_ena[i] = q_ena[i-1];
            end
            q_sel[0] = sel_rst_n;
            q_inc[0] = inc;
            q_ena[0] = en;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_addr", 32'(addr), 32'(m_addr));
            check("model_ena", 32'(ena), 32'(m_run));
            check("model_iw", 32'(iw), 32'(m_iw));
            check("model_ow", 32'(ow_out), 32'(m_ow));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_inc();
        inc = 1'b1;
        ticks(4);
        inc = 1'b0;
        ticks(4);
    endtask

    initial begin
        int lows;
        int n;
        rst_n     = 1'b0;
        sel_rst_n = 1'b1;
        inc       = 1'b0;
        en        = 1'b1;
        iw_in     = 18'h2A5A5;
        ow_in     = 24'h0;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_ena", 32'(ena), 32'h0);
        check("rst_iw", 32'(iw), 32'h0);
        check("rst_ow", 32'(ow_out), 32'h0);
        chk_en = 1'b1;

        // Release reset with selection and enable pins high
        rst_n = 1'b1;
        ticks(4);
        check("ena_before_edge5", 32'(ena), 32'h0);
        tick();
        check("ena_at_edge5", 32'(ena), 32'h1);
        check("iw_at_ena_rise", 32'(iw), 32'h0);
        check("addr_after_release", 32'(addr), 32'h0);
        tick();
        check("iw_follows", 32'(iw), 32'h2A5A5);

        // First increment pulse, literal timing
        inc = 1'b1;
        ticks(2);
        check("inc_addr_pre", 32'(addr), 32'h0);
        check("inc_ena_pre", 32'(ena), 32'h1);
        tick();
        check("inc_addr_step", 32'(addr), 32'h1);
        check("inc_ena_drop1", 32'(ena), 32'h0);
        tick();
        check("inc_ena_drop2", 32'(ena), 32'h0);
        check("inc_iw_drop", 32'(iw), 32'h0);
        inc = 1'b0;
        tick();
        check("inc_ena_back", 32'(ena), 32'h1);
        ticks(3);
        pulse_inc();
        pulse_inc();
        check("addr_three", 32'(addr), 32'h3);

        // Wrap around from 23 to 0
        for (int i = 0; i < 21; i++) pulse_inc();
        check("addr_wrap", 32'(addr), 32'h0);
        check("ena_after_wrap", 32'(ena), 32'h1);

        // Second increment lands during SETTLE and reloads the guard
        lows = 0;
        inc = 1'b1; tick(); if (!ena) lows++;
        inc = 1'b0; tick(); if (!ena) lows++;
        inc = 1'b1; tick(); if (!ena) lows++;
        inc = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (!ena) lows++;
        end
        check("settle_reload_lows", 32'(lows), 32'h4);
        check("settle_reload_addr", 32'(addr), 32'h2);

        // Selection reset held while pulsing increment
        ow_in = 24'h123456;
        sel_rst_n = 1'b0;
        pulse_inc();
        pulse_inc();
        check("selrst_addr", 32'(addr), 32'h0);
        check("selrst_ena", 32'(ena), 32'h0);
        check("selrst_ow", 32'(ow_out), 32'h0);
        sel_rst_n = 1'b1;
        ticks(5);
        check("selrst_release_ena", 32'(ena), 32'h1);
        check("selrst_release_addr", 32'(addr), 32'h0);
        pulse_inc();
        check("selrst_resume_addr", 32'(addr), 32'h1);

        // Output word capture and enable drop
        ow_in = 24'hC0FFEE;
        tick();
        check("ow_capture", 32'(ow_out), 32'hC0FFEE);
        en = 1'b0;
        ticks(2);
        check("ena_hold_after_pin", 32'(ena), 32'h1);
        tick();
        check("ena_fall_3edges", 32'(ena), 32'h0);
        check("ow_still_held", 32'(ow_out), 32'hC0FFEE);
        tick();
        check("ow_cleared", 32'(ow_out), 32'h0);

        // Asynchronous reset in RUN at address 7
        en = 1'b1;
        n = 0;
        while (m_addr != 7 && n < 40) begin
            pulse_inc();
            n++;
        end
        ticks(4);
        check("pre_rst_addr", 32'(addr), 32'h7);
        check("pre_rst_ena", 32'(ena), 32'h1);
        check("pre_rst_ow", 32'(ow_out), 32'hC0FFEE);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_addr", 32'(addr), 32'h0);
        check("async_rst_ena", 32'(ena), 32'h0);
        check("async_rst_iw", 32'(iw), 32'h0);
        check("async_rst_ow", 32'(ow_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        check("post_rst_addr", 32'(addr), 32'h0);

        // Randomized pin activity against the model
        for (int i = 0; i < 3000; i++) begin
            iw_in = 18'($urandom);
            ow_in = 24'($urandom);
            if ($urandom_range(0, 9) == 0) inc = ~inc;
            if ($urandom_range(0, 29) == 0) en = ~en;
            if (sel_rst_n) begin
                if ($urandom_range(0, 149) == 0) sel_rst_n = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                sel_rst_n = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
